pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter CNT_W, default 32: width of the pulse-count and pulses-sent fields.
REQ-002 Parameter PER_W, default 16: width of the high-phase and low-phase period fields.
REQ-003 clk  input  1  single clock; all logic rising-edge triggered.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a burst; sampled only in IDLE.
REQ-006 abort  input  1  terminate any burst in progress.
REQ-007 pulseCount  input  CNT_W  number of pulses in the burst; latched on accepted start.
REQ-008 highCycles  input  PER_W  high-phase length in cycles; latched on accepted start.
REQ-009 lowCycles  input  PER_W  low-phase length in cycles; latched on accepted start.
REQ-010 waitOnMe  input  1  release for the final high phase; tie to 1 if no wait is required.
REQ-011 pulse  output  1  generated pulse train, registered.
REQ-012 busy  output  1  high from the cycle after start is accepted until the burst ends.
REQ-013 done  output  1  one-cycle strobe on normal completion of a burst.
REQ-014 pulsesSent  output  CNT_W  count of completed pulses in the current or last burst.

Function
REQ-015 The state machine SHALL have states IDLE, HIGH, LOW and WAIT, with a registered state encoding.
REQ-016 start=1 in IDLE SHALL latch pulseCount, highCycles and lowCycles, and clear pulsesSent; with pulseCount>0 the next state is HIGH.
REQ-017 Latency: start sampled at edge N gives pulse=1 and busy=1 from cycle N+1.
REQ-018 pulse SHALL be 1 only in HIGH and WAIT, and 0 in IDLE and LOW.
REQ-019 HIGH SHALL last max(highCycles,1) cycles; LOW SHALL last max(lowCycles,1) cycles, so a zero period is treated as 1.
REQ-020 At the end of each HIGH phase, pulsesSent SHALL increment; if pulses remain, the next state is LOW, and LOW then returns to HIGH.
REQ-021 At the end of the final HIGH phase the next state SHALL be WAIT if waitOnMe=0; otherwise the burst completes, with no trailing LOW phase.
REQ-022 WAIT SHALL hold pulse=1 until waitOnMe=1 is sampled; the burst then completes on the next edge.
REQ-023 Completion: state returns to IDLE and pulse=0, busy=0 and done=1 all for exactly one cycle; pulsesSent equals the latched pulseCount.
REQ-024 pulseCount=0: start SHALL produce no pulse, busy=1 for one cycle, then done=1 in the following cycle.
REQ-025 start SHALL be ignored while busy=1; the latched configuration SHALL be unaffected.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with pulse=0, busy=0 and done=0; pulsesSent SHALL hold its value.
REQ-027 If abort and start are both 1 in IDLE, abort SHALL win and no burst starts.
REQ-028 Internal phase counters SHALL be PER_W bits and the pulse counter CNT_W bits; no wrap-around is permitted for any legal input.
REQ-029 pulsesSent SHALL saturate at the all-ones value and SHALL NOT wrap.

Reset
REQ-030 reset=1 SHALL force state IDLE, pulse=0, busy=0, done=0, pulsesSent=0 and all latched fields to 0 on the next edge.
REQ-031 reset SHALL override start and abort, and SHALL abort any burst mid-operation without asserting done.

Configuration
REQ-032 Macro PULSE_TRAIN_GEN_WAIT_EN: when defined, WAIT is implemented exactly as in REQ-021 and REQ-022.
REQ-033 When PULSE_TRAIN_GEN_WAIT_EN is undefined, the WAIT state is not built, waitOnMe is ignored but the port is kept, and the final HIGH phase always completes after max(highCycles,1) cycles.

Structure
REQ-034 A shared package pulse_gen_pkg SHALL hold the state enumeration typedef and the default parameter constants.
REQ-035 One sub-module, pulse_phase_timer, SHALL implement the loadable PER_W down-counter with a terminal-count flag, instanced once and reloaded on each phase entry.

Verification
REQ-036 pulseCount=3, highCycles=2, lowCycles=1, waitOnMe=1, start at edge 5 -> pulse high in cycles 6-7, 9-10 and 12-13; done=1 in cycle 14; pulsesSent=3.
REQ-037 pulseCount=5, highCycles=1, lowCycles=1, waitOnMe=0 until 10 cycles after the 5th pulse rises -> pulse held high through WAIT; done 1 cycle after waitOnMe is sampled high.
REQ-038 pulseCount=0 -> no pulse; busy high 1 cycle; done strobe the next cycle; pulsesSent=0.
REQ-039 pulseCount=4, abort asserted during the 2nd LOW phase -> pulse=0 and busy=0 on the next cycle; no done; pulsesSent=2.
REQ-040 start re-pulsed mid-burst with different fields, and reset asserted mid-HIGH -> re-start ignored; reset gives all outputs 0 on the next edge.
REQ-041 Build without PULSE_TRAIN_GEN_WAIT_EN, pulseCount=2, waitOnMe=0 -> burst completes normally and done is asserted.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared definitions for the pulse train generator:
//   - pulse_state_e : burst state machine encoding (IDLE, HIGH, LOW, WAIT)
//   - DEF_CNT_W     : default width of the pulse-count / pulses-sent fields
//   - DEF_PER_W     : default width of the high / low period fields
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_PER_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        WAIT = 2'd3
    } pulse_state_e;

endpackage : pulse_gen_pkg

// File: rtl/pulse_phase_timer.sv
// -----------------------------------------------------------------------------
// pulse_phase_timer
// Loadable PER_W-bit down-counter used to time the HIGH and LOW phases.
// The counter is loaded with (phase length - 1) on phase entry and counts down
// to zero, where it stops; tc is high while the count is zero, which marks the
// last cycle of the current phase.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (count cleared)
//   load     in   load load_val on the next edge
//   load_val in   PER_W  value to load
//   tc       out  terminal count (count == 0)
// -----------------------------------------------------------------------------
module pulse_phase_timer
    import pulse_gen_pkg::*;
#(
    parameter int unsigned PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    output logic             tc
);

    logic [PER_W-1:0] cnt_r;

    // Down-counter: load on phase entry, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {PER_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {PER_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(PER_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == {PER_W{1'b0}});

endmodule : pulse_phase_timer

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
// Generates a burst of pulseCount pulses, each high for max(highCycles,1)
// cycles and separated by max(lowCycles,1) low cycles. There is no trailing
// low phase after the final pulse. All outputs are registered.
//
// Optional feature (macro PULSE_TRAIN_GEN_WAIT_EN): when defined, the final
// high phase is extended in a WAIT state until waitOnMe is sampled high. When
// undefined, WAIT is not built and waitOnMe is ignored (port retained).
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   start       in   burst request, accepted only in IDLE
//   abort       in   terminate a burst in progress (wins over start)
//   pulseCount  in   CNT_W pulses per burst (latched on accepted start)
//   highCycles  in   PER_W high-phase length (latched on accepted start)
//   lowCycles   in   PER_W low-phase length  (latched on accepted start)
//   waitOnMe    in   release for the final high phase
//   pulse       out  pulse train
//   busy        out  burst in progress
//   done        out  one-cycle strobe on normal completion
//   pulsesSent  out  CNT_W completed pulses in current/last burst (saturating)
// -----------------------------------------------------------------------------
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulseCount,
    input  logic [PER_W-1:0] highCycles,
    input  logic [PER_W-1:0] lowCycles,
    input  logic             waitOnMe,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulsesSent
);

    // Timer reload value for a phase: a zero period behaves as one cycle.
    function automatic logic [PER_W-1:0] phase_load(input logic [PER_W-1:0] cycles);
        logic [PER_W-1:0] res;
        if (cycles == {PER_W{1'b0}}) begin
            res = {PER_W{1'b0}};
        end else begin
            res = cycles - {{(PER_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    pulse_state_e     state_r;
    pulse_state_e     state_next_s;

    logic [CNT_W-1:0] count_r;
    logic [PER_W-1:0] high_r;
    logic [PER_W-1:0] low_r;
    logic [CNT_W-1:0] sent_r;
    logic             pulse_r;
    logic             busy_r;
    logic             done_r;

    logic             timer_load_s;
    logic [PER_W-1:0] timer_val_s;
    logic             timer_tc_s;
    logic             latch_s;
    logic             sent_inc_s;
    logic             done_next_s;
    logic             last_pulse_s;
    logic             count_reached_s;

`ifndef PULSE_TRAIN_GEN_WAIT_EN
    logic             unused_wait_on_me_s;
    assign unused_wait_on_me_s = waitOnMe;
`endif

    // Compared one bit wider so the +1 can never wrap for an all-ones count.
    assign last_pulse_s    = (({1'b0, sent_r} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, count_r});
    // Used at the end of LOW: only true for the zero-pulse burst.
    assign count_reached_s = (sent_r >= count_r);

    pulse_phase_timer #(
        .PER_W    (PER_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .tc       (timer_tc_s)
    );

    // Next-state, timer reload and completion decode.
    always_comb begin
        state_next_s = state_r;
        timer_load_s = 1'b0;
        timer_val_s  = {PER_W{1'b0}};
        latch_s      = 1'b0;
        sent_inc_s   = 1'b0;
        done_next_s  = 1'b0;

        if (abort) begin
            // Abort ends any burst without done and also blocks a start in IDLE.
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        latch_s      = 1'b1;
                        timer_load_s = 1'b1;
                        if (pulseCount != {CNT_W{1'b0}}) begin
                            state_next_s = HIGH;
                            timer_val_s  = phase_load(highCycles);
                        end else begin
                            // Zero-pulse burst: one busy LOW cycle, then done.
                            state_next_s = LOW;
                            timer_val_s  = {PER_W{1'b0}};
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end

                HIGH: begin
                    if (timer_tc_s) begin
                        sent_inc_s = 1'b1;
                        if (!last_pulse_s) begin
                            state_next_s = LOW;
                            timer_load_s = 1'b1;
                            timer_val_s  = phase_load(low_r);
                        end else begin
`ifdef PULSE_TRAIN_GEN_WAIT_EN
                            if (!waitOnMe) begin
                                state_next_s = WAIT;
                            end else begin
                                state_next_s = IDLE;
                                done_next_s  = 1'b1;
                            end
`else
                            state_next_s = IDLE;
                            done_next_s  = 1'b1;
`endif
                        end
                    end else begin
                        state_next_s = HIGH;
                    end
                end

                LOW: begin
                    if (timer_tc_s) begin
                        if (count_reached_s) begin
                            state_next_s = IDLE;
                            done_next_s  = 1'b1;
                        end else begin
                            state_next_s = HIGH;
                            timer_load_s = 1'b1;
                            timer_val_s  = phase_load(high_r);
                        end
                    end else begin
                        state_next_s = LOW;
                    end
                end

`ifdef PULSE_TRAIN_GEN_WAIT_EN
                WAIT: begin
                    if (waitOnMe) begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = WAIT;
                    end
                end
`endif

                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State, latched configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
            high_r  <= {PER_W{1'b0}};
            low_r   <= {PER_W{1'b0}};
            sent_r  <= {CNT_W{1'b0}};
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pulse_r <= (state_next_s == HIGH) || (state_next_s == WAIT);
            busy_r  <= (state_next_s != IDLE);
            done_r  <= done_next_s;

            if (latch_s) begin
                count_r <= pulseCount;
                high_r  <= highCycles;
                low_r   <= lowCycles;
                sent_r  <= {CNT_W{1'b0}};
            end else if (sent_inc_s && !(&sent_r)) begin
                sent_r  <= sent_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                sent_r  <= sent_r;
            end
        end
    end

    assign pulse      = pulse_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pulsesSent = sent_r;

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
// Self-checking bench: a reference model expands each accepted burst into the
// list of expected per-cycle outputs (pulse, pulsesSent) and a compare process
// checks the DUT every cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

    localparam int CW = 8;
    localparam int PW = 4;

`ifdef PULSE_TRAIN_GEN_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] pulseCount;
    logic [PW-1:0] highCycles;
    logic [PW-1:0] lowCycles;
    logic          waitOnMe;
    logic          pulse;
    logic          busy;
    logic          done;
    logic [CW-1:0] pulsesSent;

    int checks   = 0;
    int failures = 0;

    pulse_train_gen #(.CNT_W(CW), .PER_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pulseCount (pulseCount),
        .highCycles (highCycles),
        .lowCycles  (lowCycles),
        .waitOnMe   (waitOnMe),
        .pulse      (pulse),
        .busy       (busy),
        .done       (done),
        .pulsesSent (pulsesSent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          p;
        logic [CW-1:0] s;
        logic          fin;
    } ent_t;

    ent_t          q[$];
    ent_t          cur;
    bit            m_valid = 1'b0;
    bit            m_busy  = 1'b0;
    bit            m_wait  = 1'b0;
    logic [CW-1:0] m_n;
    logic          e_pulse, e_busy, e_done;
    logic [CW-1:0] e_sent;

    always @(posedge clk) begin
        e_done = 1'b0;
        if (reset) begin
            q.delete();
            m_busy = 1'b0; m_wait = 1'b0;
            e_pulse = 1'b0; e_busy = 1'b0; e_sent = '0;
            m_valid = 1'b1;
        end else if (!m_busy) begin
            e_pulse = 1'b0; e_busy = 1'b0;
            if (start && !abort) begin
                int hi;
                int lo;
                hi = (highCycles == 0) ? 1 : int'(highCycles);
                lo = (lowCycles == 0) ? 1 : int'(lowCycles);
                m_n = pulseCount;
                q.delete();
                if (pulseCount == 0) begin
                    q.push_back('{p: 1'b0, s: '0, fin: 1'b0});
                end else begin
                    for (int i = 1; i <= int'(pulseCount); i++) begin
                        for (int k = 0; k < hi; k++)
                            q.push_back('{p: 1'b1, s: CW'(i - 1), fin: (i == int'(pulseCount))});
                        if (i < int'(pulseCount))
                            for (int k = 0; k < lo; k++)
                                q.push_back('{p: 1'b0, s: CW'(i), fin: 1'b0});
                    end
                end
                cur = q.pop_front();
                m_busy = 1'b1;
                e_pulse = cur.p; e_busy = 1'b1; e_sent = cur.s;
            end
        end else if (abort) begin
            q.delete();
            m_busy = 1'b0; m_wait = 1'b0;
            e_pulse = 1'b0; e_busy = 1'b0;
        end else if (m_wait) begin
            if (waitOnMe) begin
                m_busy = 1'b0; m_wait = 1'b0;
                e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_sent = m_n;
            end
        end else if (q.size() > 0) begin
            cur = q.pop_front();
            e_pulse = cur.p; e_sent = cur.s;
        end else if (cur.fin && WAIT_EN && !waitOnMe) begin
            m_wait = 1'b1;
            e_pulse = 1'b1; e_sent = m_n;
        end else begin
            m_busy = 1'b0;
            e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_sent = m_n;
        end
    end

    // Every-cycle compare of {pulse,busy,done,pulsesSent} against the model.
    always @(negedge clk) begin
        if (m_valid)
            chk("cycle_outputs", {pulse, busy, done, pulsesSent}, {e_pulse, e_busy, e_done, e_sent});
    end

    // ---------------- stimulus ----------------
    task automatic go(input logic [CW-1:0] n, input logic [PW-1:0] h, input logic [PW-1:0] l);
        pulseCount = n; highCycles = h; lowCycles = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [9:0] pv, bv, dv;
    bit         got;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; waitOnMe = 1'b1;
        pulseCount = '0; highCycles = '0; lowCycles = '0;
        @(negedge clk);
        chk("reset_state", {pulse, busy, done, pulsesSent}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic burst: 3 pulses, high 2, low 1.
        go(8'd3, 4'd2, 4'd1);
        pv = '0; bv = '0; dv = '0;
        for (int i = 0; i < 10; i++) begin
            pv = {pv[8:0], pulse}; bv = {bv[8:0], busy}; dv = {dv[8:0], done};
            if (i == 8) chk("basic_sent_at_done", pulsesSent, 32'd3);
            @(negedge clk);
        end
        chk("basic_pulse_pattern", pv, 32'b1101101100);
        chk("basic_busy_pattern",  bv, 32'b1111111100);
        chk("basic_done_pattern",  dv, 32'b0000000010);

        // Zero-pulse burst.
        go(8'd0, 4'd3, 4'd3);
        pv = '0; bv = '0; dv = '0;
        for (int i = 0; i < 3; i++) begin
            pv = {pv[8:0], pulse}; bv = {bv[8:0], busy}; dv = {dv[8:0], done};
            @(negedge clk);
        end
        chk("zero_pulse", pv[2:0], 32'b000);
        chk("zero_busy",  bv[2:0], 32'b100);
        chk("zero_done",  dv[2:0], 32'b010);
        chk("zero_sent",  pulsesSent, 32'd0);

        // Abort during the second LOW phase (idx 7..9).
        go(8'd4, 4'd2, 4'd3);
        repeat (7) @(negedge clk);
        chk("abort_pre_low2", {pulse, busy, pulsesSent}, {2'b01, 8'd2});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", {pulse, busy, done, pulsesSent}, {3'b000, 8'd2});
        @(negedge clk);
        chk("abort_no_done", done, 32'd0);

        // Restart mid-burst is ignored; reset mid-HIGH clears everything.
        go(8'd3, 4'd4, 4'd2);
        @(negedge clk);
        pulseCount = 8'd7; highCycles = 4'd1; lowCycles = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("restart_ignored_hi", {pulse, pulsesSent}, {1'b1, 8'd0});
        @(negedge clk);
        chk("restart_ignored_lo", {pulse, pulsesSent}, {1'b0, 8'd1});
        repeat (3) @(negedge clk);
        chk("mid_high_before_reset", pulse, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_high", {pulse, busy, done, pulsesSent}, 32'd0);
        @(negedge clk);
        chk("reset_no_done", done, 32'd0);

`ifdef PULSE_TRAIN_GEN_WAIT_EN
        // Final pulse held in WAIT until waitOnMe rises.
        waitOnMe = 1'b0;
        go(8'd5, 4'd1, 4'd1);
        repeat (8) @(negedge clk);
        chk("wait_fifth_rise", {pulse, pulsesSent}, {1'b1, 8'd4});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("wait_hold", {pulse, busy, done, pulsesSent}, {3'b110, 8'd5});
        end
        waitOnMe = 1'b1;
        @(negedge clk);
        chk("wait_release_done", {pulse, busy, done, pulsesSent}, {3'b001, 8'd5});
        @(negedge clk);
`else
        // Without the wait feature waitOnMe=0 must not stall completion.
        waitOnMe = 1'b0;
        go(8'd2, 4'd1, 4'd1);
        repeat (3) @(negedge clk);
        chk("nowait_done", {pulse, busy, done, pulsesSent}, {3'b001, 8'd2});
        @(negedge clk);
`endif
        waitOnMe = 1'b1;

        // Maximum count with zero periods: 255 pulses, bounded wait for done.
        go(8'd255, 4'd0, 4'd0);
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        chk("long_done_seen", got, 32'd1);
        chk("long_sent", pulsesSent, 32'd255);
        @(negedge clk);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            start      = ($urandom_range(0, 3) == 0);
            pulseCount = CW'($urandom_range(0, 5));
            highCycles = ($urandom_range(0, 9) == 0) ? 4'd15 : PW'($urandom_range(0, 3));
            lowCycles  = ($urandom_range(0, 9) == 0) ? 4'd15 : PW'($urandom_range(0, 3));
            abort      = ($urandom_range(0, 59) == 0);
            waitOnMe   = ($urandom_range(0, 2) != 0);
            reset      = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pulse_train_gen
